// File: rtl/prim_count_watch_pkg.sv
// Shared types for prim_count_watch: sparse FSM encoding and hit counter width.
// Optional hit counter is enabled by defining PRIM_COUNT_WATCH_HIT_CNT_EN.
package prim_count_watch_pkg;

  localparam int HitCntW = 8;

  // Every pair of codes differs in 4 bits, so any single or double flip lands on an illegal code.
  typedef enum logic [5:0] {
    StIdle  = 6'b101100,
    StArmed = 6'b010110,
    StHit   = 6'b110001,
    StError = 6'b001011
  } state_e;

  function automatic logic state_legal(input logic [5:0] code);
    logic ok;
    case (code)
      StIdle, StArmed, StHit, StError: ok = 1'b1;
      default:                         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/prim_count_watch_cnt.sv
// Hardened clear/increment counter: a primary up count paired with a down-counting
// complement; any divergence between the two is reported on err_o.
module prim_count_watch_cnt
  import prim_count_watch_pkg::*;
#(
  parameter int MaxVal = 2,
  parameter int CntW   = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            incr_i,
  output logic [CntW-1:0] cnt_o,
  output logic            err_o
);

  localparam logic [CntW-1:0] SatVal = CntW'(MaxVal);
  localparam logic [CntW-1:0] OneVal = CntW'(1);

  logic [CntW-1:0] cnt_r;
  logic [CntW-1:0] cnt_inv_r;

  function automatic logic pair_bad(input logic [CntW-1:0] a, input logic [CntW-1:0] b);
    return ({1'b0, a} + {1'b0, b}) != {1'b0, {CntW{1'b1}}};
  endfunction

  // Primary/complement counter pair; clear wins over increment, increment saturates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r     <= {CntW{1'b0}};
      cnt_inv_r <= {CntW{1'b1}};
    end else if (clr_i) begin
      cnt_r     <= {CntW{1'b0}};
      cnt_inv_r <= {CntW{1'b1}};
    end else if (incr_i && (cnt_r != SatVal)) begin
      cnt_r     <= cnt_r + OneVal;
      cnt_inv_r <= cnt_inv_r - OneVal;
    end else begin
      cnt_r     <= cnt_r;
      cnt_inv_r <= cnt_inv_r;
    end
  end

  assign cnt_o = cnt_r;
  assign err_o = pair_bad(cnt_r, cnt_inv_r);

endmodule

// File: rtl/prim_count_watch.sv
// Checks a primary/reverse counter pair and raises hit_o after ConsecHits matching cycles.
// Define PRIM_COUNT_WATCH_HIT_CNT_EN to build the saturating hit_cnt_o counter.
module prim_count_watch
  import prim_count_watch_pkg::*;
#(
  parameter int Width      = 8,
  parameter bit DownCmp    = 1'b0,
  parameter int ConsecHits = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [Width-1:0]   cnt_i,
  input  logic [Width-1:0]   cnt_inv_i,
  input  logic               cnt_err_i,
  input  logic               arm_i,
  input  logic               disarm_i,
  input  logic [Width-1:0]   threshold_i,
  input  logic               ack_i,
  output logic               armed_o,
  output logic               hit_o,
  output logic               err_o,
  output logic [HitCntW-1:0] hit_cnt_o
);

  localparam int              CntW    = $clog2(ConsecHits + 1);
  localparam logic [CntW-1:0] LastHit = CntW'(ConsecHits - 1);

  state_e            state_r;
  state_e            state_next_s;
  logic [Width-1:0]  thr_r;
  logic              thr_load_s;
  logic              cnt_clr_s;
  logic              cnt_incr_s;
  logic [CntW-1:0]   cnt_val_s;
  logic              cnt_err_s;
  logic              mismatch_s;
  logic              match_s;
  logic              err_set_s;
  logic              armed_s;
  logic              hit_s;
  logic              err_s;
  logic              armed_r;
  logic              hit_r;
  logic              err_r;

  function automatic logic sum_bad(input logic [Width-1:0] a, input logic [Width-1:0] b);
    return ({1'b0, a} + {1'b0, b}) != {1'b0, {Width{1'b1}}};
  endfunction

  assign mismatch_s = sum_bad(cnt_i, cnt_inv_i);
  assign match_s    = DownCmp ? (cnt_i <= thr_r) : (cnt_i >= thr_r);
  assign err_set_s  = mismatch_s | cnt_err_i | cnt_err_s | ~state_legal(state_r);

  prim_count_watch_cnt #(
    .MaxVal (ConsecHits),
    .CntW   (CntW)
  ) u_match_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr_s),
    .incr_i (cnt_incr_s),
    .cnt_o  (cnt_val_s),
    .err_o  (cnt_err_s)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= StIdle;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and match-counter control; an error overrides every other transition.
  always_comb begin
    state_next_s = state_r;
    thr_load_s   = 1'b0;
    cnt_clr_s    = 1'b0;
    cnt_incr_s   = 1'b0;
    if (err_set_s) begin
      state_next_s = StError;
    end else begin
      case (state_r)
        StIdle: begin
          if (arm_i && !disarm_i) begin
            state_next_s = StArmed;
            thr_load_s   = 1'b1;
            cnt_clr_s    = 1'b1;
          end else begin
            state_next_s = StIdle;
          end
        end
        StArmed: begin
          if (disarm_i) begin
            state_next_s = StIdle;
            cnt_clr_s    = 1'b1;
          end else if (arm_i) begin
            thr_load_s = 1'b1;
            cnt_clr_s  = 1'b1;
          end else if (match_s) begin
            cnt_incr_s = 1'b1;
            if (cnt_val_s == LastHit) begin
              state_next_s = StHit;
            end else begin
              state_next_s = StArmed;
            end
          end else begin
            cnt_clr_s = 1'b1;
          end
        end
        StHit: begin
          if (ack_i) begin
            state_next_s = StIdle;
          end else begin
            state_next_s = StHit;
          end
        end
        StError: state_next_s = StError;
        default: state_next_s = StError;
      endcase
    end
  end

  // Output decode from the upcoming state so the registered outputs track the state flop.
  always_comb begin
    armed_s = 1'b0;
    hit_s   = 1'b0;
    err_s   = 1'b0;
    case (state_next_s)
      StArmed: armed_s = 1'b1;
      StHit:   hit_s   = 1'b1;
      StError: err_s   = 1'b1;
      default: begin
        armed_s = 1'b0;
        hit_s   = 1'b0;
        err_s   = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      armed_r <= 1'b0;
      hit_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      armed_r <= armed_s;
      hit_r   <= hit_s;
      err_r   <= err_s;
    end
  end

  // Threshold capture on accepted arm.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      thr_r <= {Width{1'b0}};
    end else if (thr_load_s) begin
      thr_r <= threshold_i;
    end else begin
      thr_r <= thr_r;
    end
  end

  assign armed_o = armed_r;
  assign hit_o   = hit_r;
  assign err_o   = err_r;

`ifdef PRIM_COUNT_WATCH_HIT_CNT_EN
  logic [HitCntW-1:0] hit_cnt_r;

  // Armed->Hit transition counter; Error has no transitions so it freezes there.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_r <= {HitCntW{1'b0}};
    end else if ((state_r == StArmed) && (state_next_s == StHit) &&
                 (hit_cnt_r != {HitCntW{1'b1}})) begin
      hit_cnt_r <= hit_cnt_r + HitCntW'(1);
    end else begin
      hit_cnt_r <= hit_cnt_r;
    end
  end

  assign hit_cnt_o = hit_cnt_r;
`else
  assign hit_cnt_o = {HitCntW{1'b0}};
`endif

endmodule

// File: tb/tb_prim_count_watch.sv
// Directed scoreboard bench for prim_count_watch (up-compare and down-compare instances).
module tb_prim_count_watch;

  typedef struct packed {
    logic       armed;
    logic       hit;
    logic       err;
    logic [7:0] hc;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [7:0] cnt;
  logic [7:0] cnt_inv;
  logic       cnt_err;
  logic       arm;
  logic       disarm;
  logic [7:0] thr;
  logic       ack;

  logic       u_armed, u_hit, u_err;
  logic [7:0] u_hc;
  logic       d_armed, d_hit, d_err;
  logic [7:0] d_hc;

  int         total = 0;
  int         bad = 0;
  bit         sel_dn = 1'b0;
  logic [7:0] exp_hc = 8'h00;
  exp_t       sb_q[$];

  always #5 clk_i = ~clk_i;

  prim_count_watch #(.Width(8), .DownCmp(1'b0), .ConsecHits(2)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cnt_i(cnt), .cnt_inv_i(cnt_inv), .cnt_err_i(cnt_err),
    .arm_i(arm), .disarm_i(disarm), .threshold_i(thr), .ack_i(ack),
    .armed_o(u_armed), .hit_o(u_hit), .err_o(u_err), .hit_cnt_o(u_hc)
  );

  prim_count_watch #(.Width(8), .DownCmp(1'b1), .ConsecHits(2)) d_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cnt_i(cnt), .cnt_inv_i(cnt_inv), .cnt_err_i(cnt_err),
    .arm_i(arm), .disarm_i(disarm), .threshold_i(thr), .ack_i(ack),
    .armed_o(d_armed), .hit_o(d_hit), .err_o(d_err), .hit_cnt_o(d_hc)
  );

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cnt(input logic [7:0] v);
    cnt     = v;
    cnt_inv = ~v;
  endtask

  task automatic note_hit();
`ifdef PRIM_COUNT_WATCH_HIT_CNT_EN
    if (exp_hc != 8'hFF) exp_hc = exp_hc + 8'd1;
`endif
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      cmp({tag, "_sb_empty"}, 8'd0, 8'd1);
    end else begin
      e = sb_q.pop_front();
      cmp({tag, "_armed"}, {7'd0, sel_dn ? d_armed : u_armed}, {7'd0, e.armed});
      cmp({tag, "_hit"},   {7'd0, sel_dn ? d_hit : u_hit},     {7'd0, e.hit});
      cmp({tag, "_err"},   {7'd0, sel_dn ? d_err : u_err},     {7'd0, e.err});
      cmp({tag, "_hcnt"},  sel_dn ? d_hc : u_hc,               e.hc);
    end
  endtask

  task automatic expect_now(input logic ea, input logic eh, input logic ee, input string tag);
    exp_t e;
    e = '{armed: ea, hit: eh, err: ee, hc: exp_hc};
    sb_q.push_back(e);
    check_out(tag);
  endtask

  task automatic tick(input logic ea, input logic eh, input logic ee, input string tag);
    exp_t e;
    e = '{armed: ea, hit: eh, err: ee, hc: exp_hc};
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    check_out(tag);
  endtask

  task automatic rst_pulse(input string tag);
    rst_ni = 1'b0;
    exp_hc = 8'h00;
    #1;
    expect_now(1'b0, 1'b0, 1'b0, tag);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; set_cnt(8'h00); cnt_err = 1'b0;
    arm = 1'b0; disarm = 1'b0; thr = 8'h00; ack = 1'b0;
    #3;
    expect_now(1'b0, 1'b0, 1'b0, "reset");
    @(posedge clk_i); #1; rst_ni = 1'b1;
    tick(1'b0, 1'b0, 1'b0, "idle");

    // Basic hit after two matches, hold, ignored controls, ack.
    arm = 1'b1; thr = 8'h10;             tick(1'b1, 1'b0, 1'b0, "arm");
    arm = 1'b0; set_cnt(8'h10);          tick(1'b1, 1'b0, 1'b0, "match1");
    note_hit();                          tick(1'b0, 1'b1, 1'b0, "hit");
                                         tick(1'b0, 1'b1, 1'b0, "hit_hold");
    arm = 1'b1; disarm = 1'b1; thr = 8'h55; tick(1'b0, 1'b1, 1'b0, "hit_ignore");
    arm = 1'b0; disarm = 1'b0; ack = 1'b1;  tick(1'b0, 1'b0, 1'b0, "ack");
    ack = 1'b0;

    // Broken run restarts the consecutive count.
    set_cnt(8'h00); arm = 1'b1; thr = 8'h10; tick(1'b1, 1'b0, 1'b0, "b_arm");
    arm = 1'b0; set_cnt(8'h10);          tick(1'b1, 1'b0, 1'b0, "b_10");
    set_cnt(8'h0F);                      tick(1'b1, 1'b0, 1'b0, "b_0f");
    set_cnt(8'h10);                      tick(1'b1, 1'b0, 1'b0, "b_10b");
    note_hit();                          tick(1'b0, 1'b1, 1'b0, "b_hit");
    ack = 1'b1;                          tick(1'b0, 1'b0, 1'b0, "b_ack");
    ack = 1'b0;

    // Arm and disarm together in Idle is not accepted.
    arm = 1'b1; disarm = 1'b1;           tick(1'b0, 1'b0, 1'b0, "arm_disarm");
    arm = 1'b0; disarm = 1'b0;           tick(1'b0, 1'b0, 1'b0, "still_idle");

    // Re-arm with a higher threshold clears progress and blocks the hit.
    arm = 1'b1; thr = 8'h10;             tick(1'b1, 1'b0, 1'b0, "r_arm");
    arm = 1'b0;                          tick(1'b1, 1'b0, 1'b0, "r_match1");
    arm = 1'b1; thr = 8'h20;             tick(1'b1, 1'b0, 1'b0, "rearm");
    arm = 1'b0;                          tick(1'b1, 1'b0, 1'b0, "r_nomatch1");
                                         tick(1'b1, 1'b0, 1'b0, "r_nomatch2");
    disarm = 1'b1;                       tick(1'b0, 1'b0, 1'b0, "disarm");
    disarm = 1'b0;

    // Asynchronous reset after one match; re-arm needs two fresh matches.
    arm = 1'b1; thr = 8'h10;             tick(1'b1, 1'b0, 1'b0, "a_arm");
    arm = 1'b0;                          tick(1'b1, 1'b0, 1'b0, "a_match1");
    rst_pulse("async_rst");
    arm = 1'b1;                          tick(1'b1, 1'b0, 1'b0, "a_rearm");
    arm = 1'b0;                          tick(1'b1, 1'b0, 1'b0, "a_fresh1");
    note_hit();                          tick(1'b0, 1'b1, 1'b0, "a_hit");
    ack = 1'b1;                          tick(1'b0, 1'b0, 1'b0, "a_ack");
    ack = 1'b0;

    // Down-compare instance.
    rst_pulse("dn_rst");
    sel_dn = 1'b1;
    set_cnt(8'h04); thr = 8'h03; arm = 1'b1; tick(1'b1, 1'b0, 1'b0, "dn_arm");
    arm = 1'b0;                          tick(1'b1, 1'b0, 1'b0, "dn_04");
    set_cnt(8'h03);                      tick(1'b1, 1'b0, 1'b0, "dn_03");
    set_cnt(8'h02); note_hit();          tick(1'b0, 1'b1, 1'b0, "dn_02");
    ack = 1'b1;                          tick(1'b0, 1'b0, 1'b0, "dn_ack");
    ack = 1'b0;
    sel_dn = 1'b0;

    // Invariant mismatch is fatal and sticky until reset.
    rst_pulse("m_rst");
    set_cnt(8'h00); thr = 8'h10; arm = 1'b1; tick(1'b1, 1'b0, 1'b0, "m_arm");
    arm = 1'b0; cnt = 8'h10; cnt_inv = 8'hEE; tick(1'b0, 1'b0, 1'b1, "mismatch");
    set_cnt(8'h10);                      tick(1'b0, 1'b0, 1'b1, "err_sticky");
    arm = 1'b1;                          tick(1'b0, 1'b0, 1'b1, "err_arm");
    arm = 1'b0;
    rst_pulse("err_clear");

    // Counter error flag while in Hit drops hit and latches the error.
    arm = 1'b1;                          tick(1'b1, 1'b0, 1'b0, "e_arm");
    arm = 1'b0;                          tick(1'b1, 1'b0, 1'b0, "e_match1");
    note_hit();                          tick(1'b0, 1'b1, 1'b0, "e_hit");
    cnt_err = 1'b1;                      tick(1'b0, 1'b0, 1'b1, "cnt_err");
    cnt_err = 1'b0;                      tick(1'b0, 1'b0, 1'b1, "cnt_err_sticky");
    ack = 1'b1;                          tick(1'b0, 1'b0, 1'b1, "err_ack");
    ack = 1'b0;
    rst_pulse("hc_rst");

    // Hit counter: three hits, then saturation.
    for (int i = 0; i < 3; i++) begin
      arm = 1'b1;                        tick(1'b1, 1'b0, 1'b0, "l_arm");
      arm = 1'b0;                        tick(1'b1, 1'b0, 1'b0, "l_match1");
      note_hit();                        tick(1'b0, 1'b1, 1'b0, "l_hit");
      ack = 1'b1;                        tick(1'b0, 1'b0, 1'b0, "l_ack");
      ack = 1'b0;
    end
`ifdef PRIM_COUNT_WATCH_HIT_CNT_EN
    cmp("hit_cnt_3", u_hc, 8'd3);
    for (int i = 0; i < 297; i++) begin
      arm = 1'b1;                        tick(1'b1, 1'b0, 1'b0, "s_arm");
      arm = 1'b0;                        tick(1'b1, 1'b0, 1'b0, "s_match1");
      note_hit();                        tick(1'b0, 1'b1, 1'b0, "s_hit");
      ack = 1'b1;                        tick(1'b0, 1'b0, 1'b0, "s_ack");
      ack = 1'b0;
    end
    cmp("hit_cnt_sat", u_hc, 8'hFF);
`else
    cmp("hit_cnt_off", u_hc, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
